// File: rtl/rgmii_speed_detect.sv
// rgmii_speed_detect: classifies the RGMII link as 10M/100M/1000M from the
// toggle rate of a prescaled rx clock bit. Define SPEED_DETECT_LINK_MON_EN
// to add receive-clock loss detection (LINK_DOWN state, live link_up).
module rgmii_speed_detect #(
    parameter int         REF_CNT_WIDTH  = 7,
    parameter int         EDGE_CNT_WIDTH = 2,
    parameter int         THRESH_100M    = 32,
    parameter int         SYNC_STAGES    = 3,
    parameter int         HYST_COUNT     = 2,
    parameter int         NOCLK_WINDOWS  = 4,
    parameter logic [1:0] DEFAULT_SPEED  = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_prescale_msb,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       speed_valid,
    output logic       speed_change,
    output logic       link_up
);

    // Agree and no-clock counters share one width wide enough for either limit.
    localparam int STAT_MAX = (HYST_COUNT > NOCLK_WINDOWS) ? HYST_COUNT : NOCLK_WINDOWS;
    localparam int STAT_W   = $clog2(STAT_MAX + 1);

    localparam logic [REF_CNT_WIDTH-1:0] THRESH    = REF_CNT_WIDTH'(THRESH_100M);
    localparam logic [STAT_W-1:0]        HYST      = STAT_W'(HYST_COUNT);
    localparam logic [STAT_W-1:0]        AGREE_ONE = STAT_W'(1);

    typedef enum logic [1:0] {
        RESET_HOLD,
        MEASURE,
        CLASSIFY,
        LINK_DOWN
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0]    sync;
    logic                      edge_q;
    logic [REF_CNT_WIDTH-1:0]  ref_cnt, ref_nxt;
    logic [EDGE_CNT_WIDTH-1:0] edge_cnt, edge_nxt;
    logic                      pend, pend_nxt;
    logic [1:0]                cls, cls_nxt;
    logic [1:0]                cand, cand_nxt;
    logic [STAT_W-1:0]         agree, agree_nxt;
    logic [1:0]                speed_nxt;
    logic                      valid_nxt;
    logic                      change_nxt;
    logic                      edge_close;
    logic                      ref_close;
    logic                      classified;

`ifdef SPEED_DETECT_LINK_MON_EN
    localparam logic [STAT_W-1:0] NOCLK_LAST = STAT_W'(NOCLK_WINDOWS - 1);

    logic              empty, empty_nxt;
    logic [STAT_W-1:0] noclk, noclk_nxt;
    logic              link_nxt;

    assign classified = ~empty;
`else
    assign classified = 1'b1;
    assign link_up    = 1'b1;
`endif

    assign mii_select = (speed != 2'b10);
    assign edge_close = &edge_cnt;
    assign ref_close  = &ref_cnt;

    // Synchronise the async prescaler bit and register a one-cycle edge strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            edge_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], rx_prescale_msb};
            edge_q <= sync[SYNC_STAGES-1] ^ sync[SYNC_STAGES-2];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Window counters, hysteresis and committed outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt      <= '0;
            edge_cnt     <= '0;
            pend         <= 1'b0;
            cls          <= 2'b00;
            cand         <= DEFAULT_SPEED;
            agree        <= '0;
            speed        <= DEFAULT_SPEED;
            speed_valid  <= 1'b0;
            speed_change <= 1'b0;
`ifdef SPEED_DETECT_LINK_MON_EN
            empty        <= 1'b0;
            noclk        <= '0;
            link_up      <= 1'b0;
`endif
        end else begin
            ref_cnt      <= ref_nxt;
            edge_cnt     <= edge_nxt;
            pend         <= pend_nxt;
            cls          <= cls_nxt;
            cand         <= cand_nxt;
            agree        <= agree_nxt;
            speed        <= speed_nxt;
            speed_valid  <= valid_nxt;
            speed_change <= change_nxt;
`ifdef SPEED_DETECT_LINK_MON_EN
            empty        <= empty_nxt;
            noclk        <= noclk_nxt;
            link_up      <= link_nxt;
`endif
        end
    end

    // Next state: window measurement, classification and commit.
    always_comb begin
        state_nxt  = state;
        ref_nxt    = ref_cnt;
        edge_nxt   = edge_cnt;
        pend_nxt   = pend;
        cls_nxt    = cls;
        cand_nxt   = cand;
        agree_nxt  = agree;
        speed_nxt  = speed;
        valid_nxt  = speed_valid;
        change_nxt = 1'b0;
`ifdef SPEED_DETECT_LINK_MON_EN
        empty_nxt  = empty;
        noclk_nxt  = noclk;
        link_nxt   = link_up;
`endif
        unique case (state)
            RESET_HOLD: begin
                ref_nxt   = '0;
                edge_nxt  = '0;
                pend_nxt  = edge_q;
                state_nxt = MEASURE;
            end
            MEASURE: begin
`ifdef SPEED_DETECT_LINK_MON_EN
                if (edge_q) link_nxt = 1'b1;
`endif
                if (edge_close || ref_close) begin
                    state_nxt = CLASSIFY;
                    ref_nxt   = '0;
                    edge_nxt  = '0;
                    // An edge in the closing cycle belongs to the next window.
                    pend_nxt  = edge_q;
`ifdef SPEED_DETECT_LINK_MON_EN
                    empty_nxt = ~edge_close && (edge_cnt == '0);
`endif
                    if (edge_close) begin
                        cls_nxt = (ref_cnt >= THRESH) ? 2'b01 : 2'b10;
                    end else begin
                        cls_nxt = 2'b00;
                    end
                end else begin
                    ref_nxt  = ref_cnt + REF_CNT_WIDTH'(1);
                    edge_nxt = edge_cnt + EDGE_CNT_WIDTH'(pend)
                             + EDGE_CNT_WIDTH'(edge_q);
                    pend_nxt = 1'b0;
                end
            end
            CLASSIFY: begin
                state_nxt = MEASURE;
                pend_nxt  = pend | edge_q;
                if (classified) begin
`ifdef SPEED_DETECT_LINK_MON_EN
                    noclk_nxt = '0;
`endif
                    if (cls == cand) begin
                        if (agree < HYST) agree_nxt = agree + AGREE_ONE;
                    end else begin
                        cand_nxt  = cls;
                        agree_nxt = AGREE_ONE;
                    end
                    if (agree_nxt >= HYST) begin
                        speed_nxt  = cand_nxt;
                        valid_nxt  = 1'b1;
                        change_nxt = (cand_nxt != speed);
                    end
                end
`ifdef SPEED_DETECT_LINK_MON_EN
                else if (noclk == NOCLK_LAST) begin
                    // Receive clock lost: drop validity, keep last speed.
                    state_nxt = LINK_DOWN;
                    noclk_nxt = '0;
                    link_nxt  = 1'b0;
                    valid_nxt = 1'b0;
                    cand_nxt  = DEFAULT_SPEED;
                    agree_nxt = '0;
                end else begin
                    noclk_nxt = noclk + AGREE_ONE;
                end
`endif
            end
`ifdef SPEED_DETECT_LINK_MON_EN
            LINK_DOWN: begin
                ref_nxt  = '0;
                edge_nxt = '0;
                if (pend || edge_q) begin
                    // The reviving edge is counted in the new window.
                    state_nxt = MEASURE;
                    link_nxt  = 1'b1;
                    pend_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = MEASURE;
            end
        endcase
    end

endmodule

// File: tb/tb_rgmii_speed_detect.sv
// Self-checking bench for rgmii_speed_detect: vector table, randomized
// segments against a speed-level model, and multi-cycle corner sequences.
module tb_rgmii_speed_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       msb = 1'b0;
    logic [1:0] speed;
    logic       mii_select;
    logic       speed_valid;
    logic       speed_change;
    logic       link_up;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    int period = 0;
    bit alt    = 1'b0;
    int tog    = 0;
    int cnt    = 0;

`ifdef SPEED_DETECT_LINK_MON_EN
    localparam logic LINK_RST = 1'b0;
`else
    localparam logic LINK_RST = 1'b1;
`endif

    rgmii_speed_detect dut (
        .clk             (clk),
        .rst             (rst),
        .rx_prescale_msb (msb),
        .speed           (speed),
        .mii_select      (mii_select),
        .speed_valid     (speed_valid),
        .speed_change    (speed_change),
        .link_up         (link_up)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int gap_now();
        if (alt) return ((tog % 6) < 3) ? 4 : 20;
        return period;
    endfunction

    // Toggle generator: fixed period, 3-fast/3-slow alternation, or static.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (period == 0 && !alt) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= gap_now()) begin
                    cnt = 0;
                    msb = ~msb;
                    tog++;
                end
            end
        end
    end

    // Continuous monitor: mii_select tracks speed, change pulses mark changes.
    logic [1:0] prev_speed = 2'b10;
    logic       prev_rst   = 1'b1;
    always @(negedge clk) begin
        if (!rst && !prev_rst) begin
            chk("mon_mii", 32'(mii_select), 32'(speed != 2'b10));
            chk("mon_change", 32'(speed_change), 32'(speed != prev_speed));
            if (speed_change) pulses++;
        end
        prev_speed = speed;
        prev_rst   = rst;
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        period = 0;
        alt    = 1'b0;
        rst    = 1'b1;
        msb    = 1'b0;
        cyc(3);
        cnt    = 0;
        tog    = 0;
        rst    = 1'b0;
        cyc(1);
    endtask

    typedef struct {
        bit         do_rst;
        int         per;
        int         cycles;
        logic [1:0] exp_speed;
        logic       exp_mii;
        logic       exp_valid;
        int         exp_pulses;
    } vec_t;

    function automatic vec_t mk(bit r, int p, int c, logic [1:0] s,
                                logic m, logic v, int np);
        vec_t x;
        x.do_rst     = r;
        x.per        = p;
        x.cycles     = c;
        x.exp_speed  = s;
        x.exp_mii    = m;
        x.exp_valid  = v;
        x.exp_pulses = np;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        int         p0;
        int         cls;
        int         per;
        logic [1:0] exp_sp;
        logic [1:0] model_speed;

        // Reset values, held in reset and just after release.
        rst = 1'b1;
        cyc(3);
        chk("rst_speed", 32'(speed), 32'h2);
        chk("rst_mii", 32'(mii_select), 32'h0);
        chk("rst_valid", 32'(speed_valid), 32'h0);
        chk("rst_change", 32'(speed_change), 32'h0);
        chk("rst_link", 32'(link_up), 32'(LINK_RST));
        do_reset();
        chk("rel_speed", 32'(speed), 32'h2);
        chk("rel_valid", 32'(speed_valid), 32'h0);

        vecs.push_back(mk(1'b1, 4, 60, 2'b10, 1'b0, 1'b1, 0));
        vecs.push_back(mk(1'b1, 20, 200, 2'b01, 1'b1, 1'b1, 1));
        vecs.push_back(mk(1'b1, 200, 900, 2'b00, 1'b1, 1'b1, 1));
        vecs.push_back(mk(1'b0, 4, 400, 2'b10, 1'b0, 1'b1, 1));
`ifndef SPEED_DETECT_LINK_MON_EN
        vecs.push_back(mk(1'b0, 0, 500, 2'b00, 1'b1, 1'b1, 1));
`endif
        vecs.push_back(mk(1'b0, 20, 300, 2'b01, 1'b1, 1'b1, 1));

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            p0     = pulses;
            period = vecs[i].per;
            cyc(vecs[i].cycles);
            chk($sformatf("vec%0d_speed", i), 32'(speed), 32'(vecs[i].exp_speed));
            chk($sformatf("vec%0d_mii", i), 32'(mii_select), 32'(vecs[i].exp_mii));
            chk($sformatf("vec%0d_valid", i), 32'(speed_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
            if (vecs[i].per != 0) chk($sformatf("vec%0d_link", i), 32'(link_up), 32'h1);
        end

        // Randomized segments: each period lies well inside one speed band,
        // so the settled speed and the number of change pulses follow directly.
        do_reset();
        model_speed = 2'b10;
        for (int s = 0; s < 8; s++) begin
            cls = $urandom_range(0, 2);
            if (cls == 2) begin
                per = $urandom_range(3, 8);
                exp_sp = 2'b10;
            end else if (cls == 1) begin
                per = $urandom_range(17, 38);
                exp_sp = 2'b01;
            end else begin
                per = $urandom_range(70, 300);
                exp_sp = 2'b00;
            end
            p0     = pulses;
            period = per;
            cyc(1200);
            chk($sformatf("rnd%0d_p%0d_speed", s, per), 32'(speed), 32'(exp_sp));
            chk($sformatf("rnd%0d_p%0d_valid", s, per), 32'(speed_valid), 32'h1);
            chk($sformatf("rnd%0d_p%0d_pulses", s, per), 32'(pulses - p0),
                32'(exp_sp != model_speed));
            model_speed = exp_sp;
        end

        // Alternating 1000M/100M windows never reach agreement.
        do_reset();
        p0  = pulses;
        alt = 1'b1;
        cyc(900);
        chk("alt_speed", 32'(speed), 32'h2);
        chk("alt_valid", 32'(speed_valid), 32'h0);
        chk("alt_pulses", 32'(pulses - p0), 32'h0);
        alt = 1'b0;

        // Asynchronous reset in the middle of a 100M window.
        do_reset();
        period = 20;
        cyc(200);
        chk("mid_pre_speed", 32'(speed), 32'h1);
        cyc(25);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_speed", 32'(speed), 32'h2);
        chk("mid_mii", 32'(mii_select), 32'h0);
        chk("mid_valid", 32'(speed_valid), 32'h0);
        chk("mid_link", 32'(link_up), 32'(LINK_RST));
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk($sformatf("mid_change%0d", k), 32'(speed_change), 32'h0);
        end
        period = 0;
        msb    = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        chk("mid_post_speed", 32'(speed), 32'h2);

`ifdef SPEED_DETECT_LINK_MON_EN
        // Receive clock stops: link drops; first edge revives it.
        begin
            bit seen;
            do_reset();
            period = 4;
            cyc(100);
            chk("ld_pre_link", 32'(link_up), 32'h1);
            chk("ld_pre_valid", 32'(speed_valid), 32'h1);
            period = 0;
            cyc(700);
            chk("ld_link", 32'(link_up), 32'h0);
            chk("ld_valid", 32'(speed_valid), 32'h0);
            chk("ld_speed", 32'(speed), 32'h2);
            p0   = pulses;
            msb  = ~msb;
            seen = 1'b0;
            for (int k = 0; k < 5; k++) begin
                cyc(1);
                if (link_up) seen = 1'b1;
            end
            chk("ld_revive_5cyc", 32'(seen), 32'h1);
            period = 4;
            cyc(100);
            chk("ld_after_speed", 32'(speed), 32'h2);
            chk("ld_after_valid", 32'(speed_valid), 32'h1);
            chk("ld_after_pulses", 32'(pulses - p0), 32'h0);
            period = 0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgmii_speed_detect.md
# rgmii_speed_detect

- Parametrised PHY link-speed detector for the RGMII MAC path, in the gtx clock domain.
- Measures the toggle rate of a prescaled receive-clock bit against the local clock.
- Classifies the link as 10M, 100M or 1000M, with hysteresis and a change pulse.
- Drives `speed` for the RGMII PHY interface and `mii_select` for the MAC. With `SPEED_DETECT_LINK_MON_EN` defined, it also flags loss of receive clock.

## Interface

Parameters:
- `REF_CNT_WIDTH`, 7: reference (window) counter width; a window is at most 2^W−1 cycles.
- `EDGE_CNT_WIDTH`, 2: edge counter width; a window closes early after 2^E−1 edges.
- `THRESH_100M`, 32: reference count at or above which an edge-closed window is 100M.
- `SYNC_STAGES`, 3: synchroniser depth for `rx_prescale_msb`, minimum 2.
- `HYST_COUNT`, 2: consecutive identical classifications needed to commit; 1 commits immediately.
- `NOCLK_WINDOWS`, 4: consecutive zero-edge windows that declare link down (macro only).
- `DEFAULT_SPEED`, 2'b10: speed value held after reset.

Ports:
- `clk` in 1: gtx clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_prescale_msb` in 1: asynchronous; MSB of a free-running 3-bit counter on rx_clk.
- `speed` out 2: 00 = 10M, 01 = 100M, 10 = 1000M.
- `mii_select` out 1: 1 when `speed` is not 10.
- `speed_valid` out 1: set at the first commit; cleared by reset or link down.
- `speed_change` out 1: one-cycle pulse when `speed` changes value.
- `link_up` out 1: receive clock present; tied 1 without the macro.

## Operation

- Synchroniser: `SYNC_STAGES` flops. An edge is an XOR of the last two stages, registered once.
- The reference counter increments every cycle.
- The edge counter increments on each detected edge.
- Window close, evaluated on registered counter values. If both conditions hold in the same cycle, edge-close wins.
  - Edge-close: edge counter is all-ones. Classify 01 if ref ≥ `THRESH_100M`, else 10.
  - Ref-close: ref counter is all-ones and edge count is nonzero. Classify 00.
  - Ref-close with zero edges: empty window. No classification is made; the no-clock counter increments.
- On any close, both counters restart at 0 in the next cycle. An edge arriving in the closing cycle counts toward the new window.
- Hysteresis, using a candidate register plus an agree counter:
  - A classification equal to the candidate increments the agree counter (saturating).
  - A differing classification loads the candidate and sets agree to 1.
  - When agree reaches `HYST_COUNT`, the candidate commits to `speed`.
- Commit:
  - `speed_change` pulses only if the committed value differs from the current `speed`.
  - `speed_valid` is set.
- Any non-empty window clears the no-clock counter.
- FSM states:
  - RESET_HOLD: one cycle after reset release, with counters cleared. Goes to MEASURE.
  - MEASURE: counting. A close goes to CLASSIFY.
  - CLASSIFY: one cycle, updating hysteresis and commit. Goes to MEASURE.
  - LINK_DOWN: macro only. The first detected edge goes to MEASURE.

## Timing

- Reset values:
  - `speed` = `DEFAULT_SPEED`; `mii_select` = (`DEFAULT_SPEED` != 2'b10).
  - `speed_valid` = 0; `speed_change` = 0.
  - `link_up` = 0 with the macro, 1 without.
  - All counters 0; candidate = `DEFAULT_SPEED`.
- Latency:
  - Input toggle to edge-counter increment: `SYNC_STAGES` + 1 cycles.
  - Close to classification: 1 cycle (CLASSIFY).
  - `speed`, `mii_select`, `speed_valid` and `speed_change` update together, registered at the end of CLASSIFY.
- No counting takes place during CLASSIFY. Edges seen in CLASSIFY are held and counted in the first MEASURE cycle.
- Reset mid-window: all state clears asynchronously and no pulse is emitted.

## Configuration

- Macro: `SPEED_DETECT_LINK_MON_EN`.
- Defined:
  - `NOCLK_WINDOWS` consecutive empty windows enter LINK_DOWN.
  - On entry: `link_up` = 0, `speed_valid` = 0, hysteresis cleared; `speed` holds its last value.
  - The first edge in LINK_DOWN sets `link_up` = 1 and resumes MEASURE.
- Undefined (legacy):
  - An empty window classifies as 00 (10M).
  - `link_up` is constant 1 and there is no LINK_DOWN state.

## Test plan

All cases use default parameters, with the input toggling every N clk cycles.
- N = 4 (1000M): after 2 windows, `speed` = 10, `mii_select` = 0, `speed_valid` = 1, no `speed_change` pulse.
- N = 20 (100M) after reset: second window commits `speed` = 01, `mii_select` = 1, with exactly one `speed_change` pulse.
- N = 200 (10M): commits `speed` = 00. Switching mid-run to N = 4 gives one window with no change, then 10 with one pulse.
- Alternate classifications each window (N switching 4/20): `speed` never commits beyond the initial value (hysteresis).
- Macro on, input held static: after 4 × 128 cycles, `link_up` = 0 and `speed_valid` = 0. Resuming N = 4 gives `link_up` = 1 within 5 cycles, then `speed` = 10.
- Assert `rst` mid-window while `speed` = 01: outputs return to reset values immediately and `speed_change` stays 0.
